// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit shared definitions: op codes and FSM state encodings.
// Imported by the interface consumers and the multiply/divide unit.
package mul_div_unit_pkg;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage to multiply/divide unit bundle.
// master = pipeline side, slave = the unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// One shared adder/subtractor serves both shift-add and shift-subtract.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               bzero;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic               sgn_op;
    logic               div_op;
    logic               arith;
    logic               is_mthi;
    logic               is_mtlo;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    always_comb begin
        sgn_op  = (bus.op == MD_MULT) || (bus.op == MD_DIV);
        div_op  = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
        arith   = (bus.op == MD_MULT) || (bus.op == MD_MULTU) || div_op;
        is_mthi = (bus.op == MD_MTHI);
        is_mtlo = (bus.op == MD_MTLO);
        a_neg   = sgn_op && bus.src_a[WIDTH-1];
        b_neg   = sgn_op && bus.src_b[WIDTH-1];
        // -MIN wraps to MIN, which read unsigned is exactly 2^(WIDTH-1)
        abs_a   = a_neg ? -bus.src_a : bus.src_a;
        abs_b   = b_neg ? -bus.src_b : bus.src_b;
    end

    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH-1:0] acc_nxt;

    // Divide: carry out of the subtract means the trial fits
    always_comb begin
        add_x = is_div ? acc[2*WIDTH-1:WIDTH-1]
                       : {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_y = {1'b0, opnd};
        sum   = {1'b0, add_x}
              + {1'b0, (is_div ? ~add_y : add_y)}
              + {{(WIDTH+1){1'b0}}, is_div};
        if (is_div) begin
            if (sum[WIDTH+1])
                acc_nxt = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_nxt = {sum[WIDTH:0], acc[WIDTH-1:1]};
            else
                acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res_hi = rem;
            res_lo = bzero ? '1 : quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            bzero  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        unique case (1'b1)
                            arith: begin
                                state  <= MD_CALC;
                                cnt    <= CW'(WIDTH - 1);
                                is_div <= div_op;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                bzero  <= div_op && (bus.src_b == '0);
                                opnd   <= div_op ? abs_b : abs_a;
                                acc    <= {{WIDTH{1'b0}},
                                           (div_op ? abs_a : abs_b)};
                            end
                            is_mthi: hi_q <= bus.src_a;
                            is_mtlo: lo_q <= bus.src_a;
                            default: ;
                        endcase
                    end
                end
                MD_CALC: begin
                    if (bus.flush) begin
                        state <= MD_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                    if (!bus.flush) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign bus.busy = (state != MD_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32.
// Each task drives one scenario and checks against hand-computed values.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue at a negedge; returns at the negedge where done is seen.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int bcyc,
                         output bit got);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bcyc = 0;
        got  = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) bcyc++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op = MD_NOP;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.flush = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.done); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL rst_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL rst_lo got %h want 0", bus.lo); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int bc;
        bit got;
        issue(MD_MULT, 32'hFFFFFFFD, 32'h00000005, bc, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL mult_done got 0 want 1"); end
        n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mult_busy_at_done got %b want 0", bus.busy); end
        n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got %h want FFFFFFFF", bus.hi); end
        n_cmp++; if (bus.lo !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL mult_lo got %h want FFFFFFF1", bus.lo); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL mult_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        int bc;
        bit got;
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL multu_done got 0 want 1"); end
        n_cmp++; if (bus.hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi got %h want FFFFFFFE", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
        issue(MD_DIVU, 32'h00000064, 32'h00000007, bc, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL b2b_divu_done got 0 want 1"); end
        n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL b2b_divu_busy_cycles got %0d want 33", bc); end
        n_cmp++; if (bus.lo !== 32'h0000000E) begin n_bad++; $display("FAIL b2b_divu_lo got %h want 0000000E", bus.lo); end
        n_cmp++; if (bus.hi !== 32'h00000002) begin n_bad++; $display("FAIL b2b_divu_hi got %h want 00000002", bus.hi); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int bc;
        bit got;
        issue(MD_DIV, 32'hFFFFFFF9, 32'h00000002, bc, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL div_done got 0 want 1"); end
        n_cmp++; if (bus.lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo got %h want FFFFFFFD", bus.lo); end
        n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi got %h want FFFFFFFF", bus.hi); end
        @(negedge clk);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, bc, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL divovf_done got 0 want 1"); end
        n_cmp++; if (bus.lo !== 32'h80000000) begin n_bad++; $display("FAIL divovf_lo got %h want 80000000", bus.lo); end
        n_cmp++; if (bus.hi !== 32'h00000000) begin n_bad++; $display("FAIL divovf_hi got %h want 00000000", bus.hi); end
        @(negedge clk);
        issue(MD_DIV, 32'hFFFFFFF9, 32'h00000000, bc, got);
        n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL divz_busy_cycles got %0d want 33", bc); end
        n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divz_lo got %h want FFFFFFFF", bus.lo); end
        n_cmp++; if (bus.hi !== 32'hFFFFFFF9) begin n_bad++; $display("FAIL divz_hi got %h want FFFFFFF9", bus.hi); end
        @(negedge clk);
    endtask

    task automatic test_divzero();
        int bc;
        bit got;
        issue(MD_DIVU, 32'h00000064, 32'h00000000, bc, got);
        n_cmp++; if (!got) begin n_bad++; $display("FAIL divuz_done got 0 want 1"); end
        n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL divuz_busy_cycles got %0d want 33", bc); end
        n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divuz_lo got %h want FFFFFFFF", bus.lo); end
        n_cmp++; if (bus.hi !== 32'h00000064) begin n_bad++; $display("FAIL divuz_hi got %h want 00000064", bus.hi); end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        bus.start = 1'b1;
        bus.op    = MD_MTHI;
        bus.src_a = 32'h12345678;
        @(negedge clk);
        n_cmp++; if (bus.hi !== 32'h12345678) begin n_bad++; $display("FAIL mthi_hi got %h want 12345678", bus.hi); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %b want 0", bus.busy); end
        bus.op    = MD_MTLO;
        bus.src_a = 32'h9ABCDEF0;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.lo !== 32'h9ABCDEF0) begin n_bad++; $display("FAIL mtlo_lo got %h want 9ABCDEF0", bus.lo); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.hi !== 32'h12345678) begin n_bad++; $display("FAIL mtlo_hi_kept got %h want 12345678", bus.hi); end
    endtask

    task automatic test_mtlo_busy();
        bit got;
        bus.start = 1'b1;
        bus.op    = MD_MULT;
        bus.src_a = 32'h00000003;
        bus.src_b = 32'h00000004;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MTLO;
        bus.src_a = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.lo !== 32'h9ABCDEF0) begin n_bad++; $display("FAIL mtlo_busy_lo got %h want 9ABCDEF0", bus.lo); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mtlo_busy_busy got %b want 1", bus.busy); end
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (bus.done) got = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL mult_small_done got 0 want 1"); end
        n_cmp++; if (bus.lo !== 32'h0000000C) begin n_bad++; $display("FAIL mult_small_lo got %h want 0000000C", bus.lo); end
        n_cmp++; if (bus.hi !== 32'h00000000) begin n_bad++; $display("FAIL mult_small_hi got %h want 00000000", bus.hi); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        bit seen;
        bus.start = 1'b1;
        bus.op    = MD_MTHI;
        bus.src_a = 32'h11111111;
        @(negedge clk);
        bus.op    = MD_MTLO;
        bus.src_a = 32'h22222222;
        @(negedge clk);
        bus.op    = MD_MULT;
        bus.src_a = 32'h00000007;
        bus.src_b = 32'h00000009;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", bus.busy); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL flush_no_done got 1 want 0"); end
        n_cmp++; if (bus.hi !== 32'h11111111) begin n_bad++; $display("FAIL flush_hi got %h want 11111111", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h22222222) begin n_bad++; $display("FAIL flush_lo got %h want 22222222", bus.lo); end
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = MD_MTHI;
        bus.src_a = 32'h0BADF00D;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        n_cmp++; if (bus.hi !== 32'h11111111) begin n_bad++; $display("FAIL flush_blocks_start got %h want 11111111", bus.hi); end
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1;
        bus.op    = MD_MULT;
        bus.src_a = 32'h00000005;
        bus.src_b = 32'h00000006;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_busy got %b want 1", bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", bus.done); end
        n_cmp++; if (bus.hi !== 32'h0) begin n_bad++; $display("FAIL rstmid_hi got %h want 0", bus.hi); end
        n_cmp++; if (bus.lo !== 32'h0) begin n_bad++; $display("FAIL rstmid_lo got %h want 0", bus.lo); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_divzero();
        test_mthi_mtlo();
        test_mtlo_busy();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
